// File: rtl/mc_control_pkg.sv
// Shared types and encodings for the multi-cycle MIPS main control unit.
package mc_control_pkg;

  typedef enum logic [3:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StMemAdr = 4'd2,
    StMemRd  = 4'd3,
    StMemWb  = 4'd4,
    StMemWr  = 4'd5,
    StExec   = 4'd6,
    StRtWb   = 4'd7,
    StBranch = 4'd8,
    StAddiEx = 4'd9,
    StAddiWb = 4'd10,
    StJump   = 4'd11
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;

endpackage

// File: rtl/mc_control_decode.sv
// Moore output decode: state plus last-wait-cycle flag to datapath strobes.
module mc_control_decode
  import mc_control_pkg::*;
(
  input  state_e state_i,
  input  logic   last_wait_i,
  output ctrl_t  ctrl_o
);

  // Every strobe defaults low; each state raises only its own.
  always_comb begin
    ctrl_o = '0;
    unique case (state_i)
      StFetch: begin
        ctrl_o.mem_read  = 1'b1;
        ctrl_o.alu_src_b = SRCB_FOUR;
        ctrl_o.alu_op    = ALU_ADD;
        ctrl_o.pc_source = PCSRC_ALU;
        // Latch IR and bump PC only once the memory data is valid.
        ctrl_o.ir_write  = last_wait_i;
        ctrl_o.pc_write  = last_wait_i;
      end
      StDecode: begin
        ctrl_o.alu_src_b = SRCB_IMMSH;
        ctrl_o.alu_op    = ALU_ADD;
      end
      StMemAdr: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
        ctrl_o.alu_op    = ALU_ADD;
      end
      StMemRd: begin
        ctrl_o.mem_read = 1'b1;
        ctrl_o.iord     = 1'b1;
      end
      StMemWb: begin
        ctrl_o.mem_to_reg = 1'b1;
        ctrl_o.reg_write  = 1'b1;
      end
      StMemWr: begin
        ctrl_o.mem_write = 1'b1;
        ctrl_o.iord      = 1'b1;
      end
      StExec: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_REG;
        ctrl_o.alu_op    = ALU_FUNCT;
      end
      StRtWb: begin
        ctrl_o.reg_dst   = 1'b1;
        ctrl_o.reg_write = 1'b1;
      end
      StBranch: begin
        ctrl_o.alu_src_a     = 1'b1;
        ctrl_o.alu_src_b     = SRCB_REG;
        ctrl_o.alu_op        = ALU_SUB;
        ctrl_o.pc_write_cond = 1'b1;
        ctrl_o.pc_source     = PCSRC_ALUOUT;
      end
      StAddiEx: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
        ctrl_o.alu_op    = ALU_ADD;
      end
      StAddiWb: begin
        ctrl_o.reg_write = 1'b1;
      end
      StJump: begin
        ctrl_o.pc_write  = 1'b1;
        ctrl_o.pc_source = PCSRC_JUMP;
      end
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle MIPS main control: state register, memory wait counter, next-state logic.
module mc_control_fsm
  import mc_control_pkg::*;
#(
  parameter int unsigned MEM_WAIT = 0,
  parameter bit          EN_ADDI  = 1'b1,
  parameter bit          EN_JUMP  = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUop,
  output logic [1:0] PCSource,
  output logic       illegal_op,
  output logic [3:0] state
);

  localparam int unsigned WaitW = (MEM_WAIT == 0) ? 1 : $clog2(MEM_WAIT + 1);
  localparam logic [WaitW-1:0] WaitMax = WaitW'(MEM_WAIT);

  state_e           state_q, state_d;
  logic [WaitW-1:0] cnt_q, cnt_d;
  logic             last_wait;
  logic             illegal_d;
  ctrl_t            ctrl;

  assign last_wait = (cnt_q == WaitMax);

  // State register and wait counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StFetch;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and wait-counter update; the counter is zero outside memory states,
  // so each entry into FETCH/MEMRD/MEMWR starts a fresh count.
  always_comb begin
    state_d   = state_q;
    cnt_d     = '0;
    illegal_d = 1'b0;
    unique case (state_q)
      StFetch: begin
        if (last_wait) state_d = StDecode;
        else           cnt_d   = cnt_q + WaitW'(1);
      end
      StDecode: begin
        if (op == OP_RTYPE)                      state_d = StExec;
        else if (op == OP_LW || op == OP_SW)     state_d = StMemAdr;
        else if (op == OP_BEQ)                   state_d = StBranch;
        else if (EN_ADDI && op == OP_ADDI)       state_d = StAddiEx;
        else if (EN_JUMP && op == OP_J)          state_d = StJump;
        else begin
          state_d   = StFetch;
          illegal_d = 1'b1;
        end
      end
      StMemAdr: state_d = (op == OP_LW) ? StMemRd : StMemWr;
      StMemRd: begin
        if (last_wait) state_d = StMemWb;
        else           cnt_d   = cnt_q + WaitW'(1);
      end
      StMemWr: begin
        if (last_wait) state_d = StFetch;
        else           cnt_d   = cnt_q + WaitW'(1);
      end
      StExec:   state_d = StRtWb;
      StAddiEx: state_d = StAddiWb;
      default:  state_d = StFetch;
    endcase
  end

  mc_control_decode u_decode (
    .state_i     (state_q),
    .last_wait_i (last_wait),
    .ctrl_o      (ctrl)
  );

  // Reset masks every output so an aborted instruction leaves no stray strobe.
  always_comb begin
    PCWrite     = ctrl.pc_write      & ~reset;
    PCWriteCond = ctrl.pc_write_cond & ~reset;
    IorD        = ctrl.iord          & ~reset;
    MemRead     = ctrl.mem_read      & ~reset;
    MemWrite    = ctrl.mem_write     & ~reset;
    IRWrite     = ctrl.ir_write      & ~reset;
    MemtoReg    = ctrl.mem_to_reg    & ~reset;
    RegDst      = ctrl.reg_dst       & ~reset;
    RegWrite    = ctrl.reg_write     & ~reset;
    ALUSrcA     = ctrl.alu_src_a     & ~reset;
    ALUSrcB     = reset ? 2'b00 : ctrl.alu_src_b;
    ALUop       = reset ? 2'b00 : ctrl.alu_op;
    PCSource    = reset ? 2'b00 : ctrl.pc_source;
    illegal_op  = illegal_d & ~reset;
    state       = reset ? 4'd0 : state_q;
  end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed, table-driven bench for mc_control_fsm at MEM_WAIT=0, MEM_WAIT=2 and with j/addi disabled.
module tb_mc_control_fsm;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] op = 6'h3f;

  // Observation vector: {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
  //                      RegDst, RegWrite, ALUSrcA, ALUSrcB[1:0], ALUop[1:0], PCSource[1:0],
  //                      illegal_op, state[3:0]}
  logic [20:0] obs_w0, obs_w2, obs_nj;

  typedef struct packed {
    logic [5:0]  op;
    logic [20:0] exp;
  } vec_t;

  vec_t tab[$];
  int   total = 0;
  int   bad   = 0;

  localparam logic [5:0] X = 6'h3f;

  always #5 clk = ~clk;

  mc_control_fsm #(.MEM_WAIT(0), .EN_ADDI(1'b1), .EN_JUMP(1'b1)) u_w0 (
    .clk(clk), .reset(reset), .op(op),
    .PCWrite(obs_w0[20]), .PCWriteCond(obs_w0[19]), .IorD(obs_w0[18]), .MemRead(obs_w0[17]),
    .MemWrite(obs_w0[16]), .IRWrite(obs_w0[15]), .MemtoReg(obs_w0[14]), .RegDst(obs_w0[13]),
    .RegWrite(obs_w0[12]), .ALUSrcA(obs_w0[11]), .ALUSrcB(obs_w0[10:9]), .ALUop(obs_w0[8:7]),
    .PCSource(obs_w0[6:5]), .illegal_op(obs_w0[4]), .state(obs_w0[3:0])
  );

  mc_control_fsm #(.MEM_WAIT(2), .EN_ADDI(1'b1), .EN_JUMP(1'b1)) u_w2 (
    .clk(clk), .reset(reset), .op(op),
    .PCWrite(obs_w2[20]), .PCWriteCond(obs_w2[19]), .IorD(obs_w2[18]), .MemRead(obs_w2[17]),
    .MemWrite(obs_w2[16]), .IRWrite(obs_w2[15]), .MemtoReg(obs_w2[14]), .RegDst(obs_w2[13]),
    .RegWrite(obs_w2[12]), .ALUSrcA(obs_w2[11]), .ALUSrcB(obs_w2[10:9]), .ALUop(obs_w2[8:7]),
    .PCSource(obs_w2[6:5]), .illegal_op(obs_w2[4]), .state(obs_w2[3:0])
  );

  mc_control_fsm #(.MEM_WAIT(0), .EN_ADDI(1'b0), .EN_JUMP(1'b0)) u_nj (
    .clk(clk), .reset(reset), .op(op),
    .PCWrite(obs_nj[20]), .PCWriteCond(obs_nj[19]), .IorD(obs_nj[18]), .MemRead(obs_nj[17]),
    .MemWrite(obs_nj[16]), .IRWrite(obs_nj[15]), .MemtoReg(obs_nj[14]), .RegDst(obs_nj[13]),
    .RegWrite(obs_nj[12]), .ALUSrcA(obs_nj[11]), .ALUSrcB(obs_nj[10:9]), .ALUop(obs_nj[8:7]),
    .PCSource(obs_nj[6:5]), .illegal_op(obs_nj[4]), .state(obs_nj[3:0])
  );

  function automatic logic [20:0] mk(input logic pcw, input logic pcwc, input logic iord,
                                     input logic mrd, input logic mwr, input logic irw,
                                     input logic m2r, input logic rdst, input logic rw,
                                     input logic asa, input logic [1:0] asb,
                                     input logic [1:0] aop, input logic [1:0] pcs,
                                     input logic ill, input logic [3:0] st);
    return {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa, asb, aop, pcs, ill, st};
  endfunction

  logic [20:0] e_f, e_fl, e_d, e_di, e_ma, e_mr, e_mwb, e_mw, e_ex, e_rt, e_br, e_aex, e_awb, e_j;

  function automatic logic [20:0] pick(input int sel);
    if (sel == 0) return obs_w0;
    else if (sel == 1) return obs_w2;
    else return obs_nj;
  endfunction

  task automatic check(input logic [20:0] act, input logic [20:0] exp, input string name);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Hold reset for two edges and check every instance is fully masked.
  task automatic do_reset();
    reset = 1'b1;
    op    = X;
    repeat (2) @(posedge clk);
    #1;
    check(obs_w0, 21'h0, "reset_w0");
    check(obs_w2, 21'h0, "reset_w2");
    check(obs_nj, 21'h0, "reset_nj");
    reset = 1'b0;
  endtask

  // Each row is one cycle: drive op, compare, advance one edge.
  task automatic run_tab(input int sel, input string tag);
    for (int i = 0; i < tab.size(); i++) begin
      op = tab[i].op;
      #1;
      check(pick(sel), tab[i].exp, $sformatf("%s_row%0d", tag, i));
      @(posedge clk);
      #1;
    end
  endtask

  task automatic add(input logic [5:0] o, input logic [20:0] e);
    tab.push_back({o, e});
  endtask

  initial begin
    e_f   = mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 0, 4'd0);
    e_fl  = mk(1, 0, 0, 1, 0, 1, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 0, 4'd0);
    e_d   = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 2'b00, 0, 4'd1);
    e_di  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 2'b00, 1, 4'd1);
    e_ma  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00, 0, 4'd2);
    e_mr  = mk(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 4'd3);
    e_mwb = mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 2'b00, 0, 4'd4);
    e_mw  = mk(0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 4'd5);
    e_ex  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b10, 2'b00, 0, 4'd6);
    e_rt  = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 0, 4'd7);
    e_br  = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 2'b01, 0, 4'd8);
    e_aex = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00, 0, 4'd9);
    e_awb = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 0, 4'd10);
    e_j   = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b10, 0, 4'd11);

    // Phase 1: MEM_WAIT=0, every instruction class back to back; junk op outside decode.
    do_reset();
    tab.delete();
    add(X, e_fl); add(6'h00, e_d); add(X, e_ex); add(X, e_rt);                    // R-type
    add(X, e_fl); add(6'h23, e_d); add(6'h23, e_ma); add(X, e_mr); add(X, e_mwb); // lw
    add(X, e_fl); add(6'h04, e_d); add(X, e_br);                                  // beq
    add(X, e_fl); add(6'h08, e_d); add(X, e_aex); add(X, e_awb);                  // addi
    add(X, e_fl); add(6'h2b, e_d); add(6'h2b, e_ma); add(X, e_mw);                // sw
    add(X, e_fl); add(6'h02, e_d); add(X, e_j);                                   // j
    add(X, e_fl); add(6'h3f, e_di); add(X, e_fl);                                 // illegal
    run_tab(0, "w0");

    // Phase 2: MEM_WAIT=2, lw (9 cycles) then sw interrupted by reset mid-write.
    do_reset();
    tab.delete();
    add(X, e_f); add(X, e_f); add(X, e_fl); add(6'h23, e_d); add(6'h23, e_ma);
    add(X, e_mr); add(X, e_mr); add(X, e_mr); add(X, e_mwb);
    add(X, e_f); add(X, e_f); add(X, e_fl); add(6'h2b, e_d); add(6'h2b, e_ma);
    add(X, e_mw); add(X, e_mw);
    run_tab(1, "w2");

    // Now in the third MEMWR cycle; abort it with a 3-cycle reset.
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      check(obs_w2, 21'h0, $sformatf("w2_midreset%0d", k));
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
    #1;
    check(obs_w2, e_f, "w2_after_reset_fetch");
    @(posedge clk);
    #1;
    check(obs_w2, e_f, "w2_after_reset_fetch2");
    @(posedge clk);
    #1;
    check(obs_w2, e_fl, "w2_after_reset_fetch3");

    // Phase 3: j and addi disabled decode as illegal.
    do_reset();
    tab.delete();
    add(X, e_fl); add(6'h02, e_di); add(X, e_fl); add(6'h08, e_di);
    add(X, e_fl); add(6'h00, e_d); add(X, e_ex); add(X, e_rt); add(X, e_fl);
    run_tab(2, "nj");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mc_control_fsm.md
# mc_control_fsm

Multi-cycle MIPS main control unit, the sequential successor to the single-cycle opcode decoder. It steps each instruction through fetch, decode, execute, memory and write-back states. It drives the shared-datapath strobes (PC, IR, memory, register file, ALU muxes) from a Moore state machine. Memory wait states are parametrised, and the supported instruction set extends to addi and j.

## Interface
- MEM_WAIT, 0: extra wait cycles for every memory access (instruction fetch, load, store); legal range 0..15.
- EN_ADDI, 1: 1 = addi (op 001000) supported; 0 = treated as illegal.
- EN_JUMP, 1: 1 = j (op 000010) supported; 0 = treated as illegal.
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- op  in  6  opcode field from the instruction register; sampled only in DECODE.
- PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA  out  1 each  datapath strobes.
- ALUSrcB  out  2  00 = reg B, 01 = constant 4, 10 = sign-extended imm, 11 = imm<<2.
- ALUop  out  2  00 = add, 01 = subtract (beq), 10 = funct-decoded (R-type).
- PCSource  out  2  00 = ALU result, 01 = ALUOut (branch target), 10 = jump target.
- illegal_op  out  1  one-cycle pulse in DECODE for an unsupported opcode.
- state  out  4  current state encoding, for debug.

## Operation
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, RTWB, BRANCH, ADDIEX, ADDIWB, JUMP.
- Outputs are a pure function of the state register and the wait counter (Moore). Every output not listed for a state is 0.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUop=00, PCSource=00. IRWrite=1 and PCWrite=1 only on the last fetch cycle (wait counter == MEM_WAIT).
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUop=00. Next state by op:
  - 000000 → EXEC.
  - 100011 or 101011 → MEMADR.
  - 000100 → BRANCH.
  - 001000 → ADDIEX.
  - 000010 → JUMP.
  - Otherwise → FETCH with illegal_op=1.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUop=00. Next state MEMRD if op=100011, else MEMWR.
- MEMRD: MemRead=1, IorD=1, for MEM_WAIT+1 cycles, then MEMWB.
- MEMWB: RegDst=0, MemtoReg=1, RegWrite=1, then FETCH.
- MEMWR: MemWrite=1, IorD=1, for MEM_WAIT+1 cycles, then FETCH.
- EXEC: ALUSrcA=1, ALUSrcB=00, ALUop=10, then RTWB.
- RTWB: RegDst=1, MemtoReg=0, RegWrite=1, then FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUop=01, PCWriteCond=1, PCSource=01, then FETCH.
- ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUop=00, then ADDIWB.
- ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1, then FETCH.
- JUMP: PCWrite=1, PCSource=10, then FETCH.
- Wait counter:
  - Width max(1, clog2(MEM_WAIT+1)).
  - Clears on entry to FETCH, MEMRD and MEMWR.
  - Increments each cycle in those states until it equals MEM_WAIT, then the state advances.
  - Holds at 0 in all other states.

## Timing
- reset high at a clock edge → state=FETCH and wait counter=0 on the following cycle.
- All outputs are forced to 0 while reset is high.
- The first cycle after reset deasserts is FETCH.
- Reset mid-instruction (including mid-wait) aborts immediately. No partial RegWrite, MemWrite or PCWrite follows.
- Cycles per instruction, where W = MEM_WAIT:
  - R-type: 4+W.
  - lw: 5+2W.
  - sw: 4+2W.
  - beq: 3+W.
  - addi: 4+W.
  - j: 3+W.
  - illegal: 2+W.
- op is ignored outside DECODE and MEMADR; changes at other times have no effect.
- IRWrite and PCWrite in FETCH are single-cycle pulses regardless of W.
- MemRead in MEMRD and MemWrite in MEMWR are held high for W+1 consecutive cycles.

## Structure
- Package mc_control_pkg holds:
  - State enum (4-bit).
  - Opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J.
  - ALUop encodings: ALU_ADD, ALU_SUB, ALU_FUNCT.
  - ALUSrcB and PCSource encodings.
- Sub-module mc_control_decode (combinational) maps state plus last-wait-cycle flag to the strobe vector.
- mc_control_fsm keeps the state register, wait counter and next-state logic.

## Test plan
- Reset held 3 cycles mid-MEMWR with MEM_WAIT=2 → all outputs 0 during reset; state=FETCH next cycle; no further MemWrite.
- op=000000, MEM_WAIT=0 → states FETCH, DECODE, EXEC, RTWB, FETCH. RegWrite=1 with RegDst=1 only in cycle 4; ALUop=10 only in EXEC.
- op=100011, MEM_WAIT=2 → FETCH lasts 3 cycles with IRWrite high only in the 3rd. MEMRD lasts 3 cycles with MemRead=1 and IorD=1 throughout. MEMWB asserts RegWrite=1 and MemtoReg=1. Total 9 cycles.
- op=000100 → BRANCH asserts PCWriteCond=1, PCSource=01, ALUop=01 for one cycle, then FETCH. Total 3 cycles at W=0.
- EN_JUMP=0, op=000010 → illegal_op pulses 1 cycle in DECODE; next state FETCH; PCWrite never asserted outside FETCH.
- EN_ADDI=1, op=001000, then back-to-back sw → ADDIEX shows ALUSrcB=10; ADDIWB shows RegWrite=1, RegDst=0, MemtoReg=0. The sw then takes 4 cycles with one MemWrite cycle at W=0.
